mux_scan_ctrl: RTL



---
 rtl/mux_scan_pkg.sv | 22 ++
 rtl/mux_scan_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel scan controller that sits
// in front of the registered 4:1 mux.
package mux_scan_pkg;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int NUM_CH      = 4;
    localparam int SEL_W       = 2;
    localparam int MAX_LATENCY = 7;
    // Settle counter only has to reach MAX_LATENCY-1, so three bits are enough.
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    localparam logic [SEL_W-1:0] FIRST_CH = '0;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

endpackage

// File: rtl/mux_scan_ctrl.sv
// Scans the select lines of a registered 4:1 mux through channels 0..3,
// waits out the mux latency on each channel, samples f, and hands the
// assembled 4-bit frame downstream on a valid/ready handshake.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no scan in progress; waiting for start
//  SETTLE  | select is stable, waiting MUX_LATENCY cycles for f to follow
//  CAPTURE | f reflects the current channel; sample it into frame_o[ch]
//  HOLD    | complete frame on frame_o, frame_valid high, waiting ready
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int MUX_LATENCY  = 1,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              f,
    output logic              s0,
    output logic              s1,
    output logic [NUM_CH-1:0] frame_o,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy,
    output logic              start_ignored
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(MUX_LATENCY - 1);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ch, ch_nxt;
    logic [SEL_W-1:0]   sel, sel_nxt;
    logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
    logic [NUM_CH-1:0]  frame_nxt;
    logic               valid_nxt;
    logic               ignored_nxt;

    // State, counters and all registered outputs; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ch            <= FIRST_CH;
            sel           <= FIRST_CH;
            settle_cnt    <= '0;
            frame_o       <= '0;
            frame_valid   <= 1'b0;
            start_ignored <= 1'b0;
        end else begin
            state         <= state_nxt;
            ch            <= ch_nxt;
            sel           <= sel_nxt;
            settle_cnt    <= settle_cnt_nxt;
            frame_o       <= frame_nxt;
            frame_valid   <= valid_nxt;
            start_ignored <= ignored_nxt;
        end
    end

    // Next-state and next-output decode for the scan sequence.
    always_comb begin
        state_nxt      = state;
        ch_nxt         = ch;
        sel_nxt        = sel;
        settle_cnt_nxt = settle_cnt;
        frame_nxt      = frame_o;
        valid_nxt      = frame_valid;
        ignored_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    sel_nxt        = FIRST_CH;
                    ch_nxt         = FIRST_CH;
                    settle_cnt_nxt = '0;
                    state_nxt      = SETTLE;
                end
            end

            SETTLE: begin
                ignored_nxt    = start;
                settle_cnt_nxt = settle_cnt + 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CAPTURE;
                end
            end

            CAPTURE: begin
                ignored_nxt   = start;
                frame_nxt[ch] = f;
                // Leaving channel 3 is explicit; ch never wraps inside a frame.
                if (ch != LAST_CH) begin
                    ch_nxt         = ch + 1'b1;
                    sel_nxt        = ch + 1'b1;
                    settle_cnt_nxt = '0;
                    state_nxt      = SETTLE;
                end else begin
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (frame_ready) begin
                    valid_nxt = 1'b0;
                    sel_nxt   = FIRST_CH;
                    // A start coinciding with the handshake chains straight
                    // into the next scan instead of being dropped.
                    if (AUTO_RESTART || start) begin
                        ch_nxt         = FIRST_CH;
                        settle_cnt_nxt = '0;
                        state_nxt      = SETTLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    ignored_nxt = start;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign s0   = sel[0];
    assign s1   = sel[1];
    assign busy = (state != IDLE);

endmodule
